operand_fetch: RTL and testbench

- Read-side client of the 8-entry register file. Accepts decoded instructions and drives the file's two read address pointers (`rd_addrA`, `rd_addrB`).
- Captures the returned operands, forwarding a same-cycle writeback, and hands {A, B, dest, tag} to execute over a valid/ready interface.
- A 2-entry skid buffer gives full throughput with registered `in_ready`.

---
 rtl/op_pkg.sv | 56 +++++
 rtl/fetch_skid.sv | 100 ++++++++++
 rtl/operand_fetch.sv | 130 +++++++++++++
 tb/tb_operand_fetch.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/op_pkg.sv
// ---------------------------------------------------------------------------
// op_pkg
// Shared types for the operand fetch stage.
//   pw, dw, tw      : register address, data and tag widths
//   reg_addr_t      : register file address
//   word_t          : register data word
//   tag_t           : opaque instruction tag (opcode/immediate carried through)
//   fetch_state_t   : occupancy of the 2-entry skid buffer
//   fetch_bundle_t  : {a, b, rd, wr, tag} handed to execute
//   select_operand  : r0 / writeback-forward / register-file operand select
// ---------------------------------------------------------------------------
package op_pkg;

    localparam int pw    = 3;
    localparam int dw    = 8;
    localparam int tw    = 9;
    localparam int nregs = 1 << pw;

    typedef logic [pw-1:0] reg_addr_t;
    typedef logic [dw-1:0] word_t;
    typedef logic [tw-1:0] tag_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } fetch_state_t;

    typedef struct packed {
        word_t     a;
        word_t     b;
        reg_addr_t rd;
        logic      wr;
        tag_t      tag;
    } fetch_bundle_t;

    // r0 always reads as zero, so a writeback to r0 can never be forwarded:
    // the zero test comes first and shadows the forward compare.
    function automatic word_t select_operand(
        input reg_addr_t src,
        input logic      wb_en,
        input reg_addr_t wb_addr,
        input word_t     wb_dat,
        input word_t     rf_dat
    );
        word_t result;
        if (src == '0)
            result = '0;
        else if (wb_en && (wb_addr == src))
            result = wb_dat;
        else
            result = rf_dat;
        return result;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// ---------------------------------------------------------------------------
// fetch_skid
// Two-entry valid/ready skid buffer over fetch_bundle_t. The main register
// drives the outputs; the skid register absorbs the one bundle that can
// arrive while the consumer stalls, so in_ready can be a pure register
// without losing throughput.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : upstream handshake (in_ready registered)
//   in_data               : bundle offered upstream
//   out_valid / out_ready : downstream handshake
//   out_data              : bundle presented downstream (held while stalled)
// ---------------------------------------------------------------------------
module fetch_skid
    import op_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  fetch_bundle_t in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output fetch_bundle_t out_data
);

    fetch_state_t  state_reg;
    fetch_state_t  state_next;
    fetch_bundle_t main_reg;
    fetch_bundle_t skid_reg;
    logic          ready_reg;

    logic          accept;
    logic          fire;
    logic          load_main_in;
    logic          load_main_skid;
    logic          load_skid;

    always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        accept         = in_valid && ready_reg;
        fire           = (state_reg != EMPTY) && out_ready;

        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_next   = ONE;
                end
            end
            ONE: begin
                if (accept && fire) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    load_skid  = 1'b1;
                    state_next = TWO;
                end else if (fire) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                // ready_reg is low here, so no accept can coincide
                if (fire) begin
                    load_main_skid = 1'b1;
                    state_next     = ONE;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
            ready_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            // Registered ready: look ahead at the next state so the flag is
            // already low in the cycle the buffer is full.
            ready_reg <= (state_next != TWO);
            if (load_main_in)
                main_reg <= in_data;
            else if (load_main_skid)
                main_reg <= skid_reg;
            if (load_skid)
                skid_reg <= in_data;
        end
    end

    assign in_ready  = ready_reg;
    assign out_valid = (state_reg != EMPTY);
    assign out_data  = main_reg;

endmodule

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
// Read-side client of the 8-entry register file. Drives the two read
// addresses straight from the incoming instruction, captures the returned
// operands (forcing r0 to zero and forwarding a same-cycle writeback), and
// hands {a, b, rd, wr, tag} to execute through a 2-entry skid buffer.
//
// Optional build macro OPFETCH_SCOREBOARD_EN: keeps a per-register pending
// mask and stalls in_ready while a source register is still awaiting its
// writeback. Without it, hazards are the upstream's responsibility.
//
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   in_valid / in_ready              : decoded-instruction handshake
//   in_rs_a, in_rs_b, in_rd, in_wr   : sources, destination, write flag
//   in_tag                           : passthrough tag
//   rd_addrA, rd_addrB               : register file read addresses
//   datA_in, datB_in                 : register file read data (combinational)
//   wb_en, wb_addr, wb_dat           : register file writeback this cycle
//   out_valid / out_ready            : operand bundle handshake
//   out_a, out_b, out_rd, out_wr,
//   out_tag                          : operand bundle
// Widths pw/dw/tw must match the op_pkg constants used by the bundle type.
// ---------------------------------------------------------------------------
module operand_fetch #(
    parameter int pw = 3,
    parameter int dw = 8,
    parameter int tw = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [pw-1:0] in_rs_a,
    input  logic [pw-1:0] in_rs_b,
    input  logic [pw-1:0] in_rd,
    input  logic          in_wr,
    input  logic [tw-1:0] in_tag,
    output logic [pw-1:0] rd_addrA,
    output logic [pw-1:0] rd_addrB,
    input  logic [dw-1:0] datA_in,
    input  logic [dw-1:0] datB_in,
    input  logic          wb_en,
    input  logic [pw-1:0] wb_addr,
    input  logic [dw-1:0] wb_dat,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [dw-1:0] out_a,
    output logic [dw-1:0] out_b,
    output logic [pw-1:0] out_rd,
    output logic          out_wr,
    output logic [tw-1:0] out_tag
);

    import op_pkg::*;

    fetch_bundle_t new_bundle;
    fetch_bundle_t out_bundle;
    logic          skid_in_ready;
    logic          stall;
    logic          push_valid;

    assign rd_addrA = in_rs_a;
    assign rd_addrB = in_rs_b;

    always_comb begin
        new_bundle     = '0;
        new_bundle.a   = select_operand(in_rs_a, wb_en, wb_addr, wb_dat, datA_in);
        new_bundle.b   = select_operand(in_rs_b, wb_en, wb_addr, wb_dat, datB_in);
        new_bundle.rd  = in_rd;
        new_bundle.wr  = in_wr;
        new_bundle.tag = in_tag;
    end

`ifdef OPFETCH_SCOREBOARD_EN
    logic [(1<<pw)-1:0] pending_reg;
    logic [(1<<pw)-1:0] pending_next;
    logic [(1<<pw)-1:0] set_vec;
    logic [(1<<pw)-1:0] clr_vec;
    logic               accept;

    assign accept = in_valid && in_ready;

    // Set has priority over clear so an instruction that re-targets a
    // register being written back this cycle still marks it pending.
    // r0 is never marked: its value is constant.
    generate
        for (genvar gi = 0; gi < (1 << pw); gi++) begin : g_pending
            assign set_vec[gi]      = (gi != 0) && accept && in_wr && (in_rd == pw'(gi));
            assign clr_vec[gi]      = wb_en && (wb_addr == pw'(gi));
            assign pending_next[gi] = set_vec[gi] | (pending_reg[gi] & ~clr_vec[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending_reg <= '0;
        else
            pending_reg <= pending_next;
    end

    // A source whose writeback lands this cycle is released immediately; the
    // forwarding mux supplies the value being written.
    assign stall = (pending_reg[in_rs_a] & ~clr_vec[in_rs_a]) |
                   (pending_reg[in_rs_b] & ~clr_vec[in_rs_b]);
`else
    assign stall = 1'b0;
`endif

    assign push_valid = in_valid && !stall;
    assign in_ready   = skid_in_ready && !stall;

    fetch_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (push_valid),
        .in_ready  (skid_in_ready),
        .in_data   (new_bundle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_bundle)
    );

    assign out_a   = out_bundle.a;
    assign out_b   = out_bundle.b;
    assign out_rd  = out_bundle.rd;
    assign out_wr  = out_bundle.wr;
    assign out_tag = out_bundle.tag;

endmodule

// File: tb/tb_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch
// Directed bench for operand_fetch with a small register file model.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Build with OPFETCH_SCOREBOARD_EN defined to exercise the hazard stall.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_operand_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_rs_a;
    logic [2:0] in_rs_b;
    logic [2:0] in_rd;
    logic       in_wr;
    logic [8:0] in_tag;
    logic [2:0] rd_addrA;
    logic [2:0] rd_addrB;
    logic [7:0] datA_in;
    logic [7:0] datB_in;
    logic       wb_en;
    logic [2:0] wb_addr;
    logic [7:0] wb_dat;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic [2:0] out_rd;
    logic       out_wr;
    logic [8:0] out_tag;

    logic [7:0] regs [8];
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    assign datA_in = regs[rd_addrA];
    assign datB_in = regs[rd_addrB];

    operand_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs_a   (in_rs_a),
        .in_rs_b   (in_rs_b),
        .in_rd     (in_rd),
        .in_wr     (in_wr),
        .in_tag    (in_tag),
        .rd_addrA  (rd_addrA),
        .rd_addrB  (rd_addrB),
        .datA_in   (datA_in),
        .datB_in   (datB_in),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_dat    (wb_dat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_rd    (out_rd),
        .out_wr    (out_wr),
        .out_tag   (out_tag)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One clock; the register file model commits the writeback that was
    // presented during the cycle, after the DUT has sampled it.
    task automatic step();
        @(posedge clk);
        #1;
        if (wb_en)
            regs[wb_addr] = wb_dat;
    endtask

    task automatic offer(input logic [2:0] a, input logic [2:0] b, input logic [2:0] rd,
                         input logic wr, input logic [8:0] tag);
        in_valid = 1'b1;
        in_rs_a  = a;
        in_rs_b  = b;
        in_rd    = rd;
        in_wr    = wr;
        in_tag   = tag;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        regs[0] = 8'h77; regs[1] = 8'h22; regs[2] = 8'h01; regs[3] = 8'h5A;
        regs[4] = 8'h11; regs[5] = 8'h44; regs[6] = 8'h66; regs[7] = 8'h88;
        rst_n = 1'b0; in_valid = 1'b0; in_rs_a = '0; in_rs_b = '0; in_rd = '0;
        in_wr = 1'b0; in_tag = '0; wb_en = 1'b0; wb_addr = '0; wb_dat = '0;
        out_ready = 1'b0;

        // Reset state
        step(); step();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("rst_out_a",     32'(out_a),     32'd0);
        check_eq("rst_out_tag",   32'(out_tag),   32'd0);
        rst_n = 1'b1;

        // Single fetch r3/r4
        offer(3'd3, 3'd4, 3'd1, 1'b0, 9'h0A1);
        step();
        in_valid = 1'b0;
        check_eq("single_valid", 32'(out_valid), 32'd1);
        check_eq("single_a",     32'(out_a),     32'h5A);
        check_eq("single_b",     32'(out_b),     32'h11);
        check_eq("single_rd",    32'(out_rd),    32'd1);
        check_eq("single_tag",   32'(out_tag),   32'h0A1);
        out_ready = 1'b1;
        step();
        check_eq("single_drain", 32'(out_valid), 32'd0);

        // r0 sources ignore both the register file and a writeback to r0
        out_ready = 1'b0;
        offer(3'd0, 3'd0, 3'd2, 1'b0, 9'h100);
        wb_en = 1'b1; wb_addr = 3'd0; wb_dat = 8'hFF;
        step();
        in_valid = 1'b0; wb_en = 1'b0;
        check_eq("r0_a", 32'(out_a), 32'd0);
        check_eq("r0_b", 32'(out_b), 32'd0);
        out_ready = 1'b1;
        step();

        // Forwarding on A (r2 written 0x7E the same cycle), B from file r3
        out_ready = 1'b0;
        offer(3'd2, 3'd3, 3'd6, 1'b1, 9'h0F0);
        wb_en = 1'b1; wb_addr = 3'd2; wb_dat = 8'h7E;
        step();
        in_valid = 1'b0;
        check_eq("fwd_a",  32'(out_a),  32'h7E);
        check_eq("fwd_b",  32'(out_b),  32'h5A);
        check_eq("fwd_wr", 32'(out_wr), 32'd1);
        // Later writeback to r3 must not alter the held bundle
        wb_addr = 3'd3; wb_dat = 8'h99;
        step();
        wb_en = 1'b0;
        check_eq("final_b", 32'(out_b), 32'h5A);
        check_eq("final_a", 32'(out_a), 32'h7E);
        out_ready = 1'b1;
        step();
        check_eq("fwd_drain", 32'(out_valid), 32'd0);

        // Back-pressure: three bundles, two held
        out_ready = 1'b0;
        offer(3'd1, 3'd1, 3'd0, 1'b0, 9'd1);
        step();
        check_eq("bp1_ready", 32'(in_ready), 32'd1);
        check_eq("bp1_tag",   32'(out_tag),  32'd1);
        in_tag = 9'd2;
        step();
        check_eq("bp2_ready", 32'(in_ready), 32'd0);
        check_eq("bp2_tag",   32'(out_tag),  32'd1);
        in_tag = 9'd3;
        step();
        check_eq("bp3_hold_tag", 32'(out_tag),   32'd1);
        check_eq("bp3_ready",    32'(in_ready),  32'd0);
        out_ready = 1'b1;
        step();
        check_eq("bp_out2_tag",   32'(out_tag),  32'd2);
        check_eq("bp_out2_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_eq("bp_out3_valid", 32'(out_valid), 32'd1);
        check_eq("bp_out3_tag",   32'(out_tag),   32'd3);
        step();
        check_eq("bp_drain", 32'(out_valid), 32'd0);

        // Asynchronous reset while two bundles are held
        out_ready = 1'b0;
        offer(3'd3, 3'd4, 3'd0, 1'b0, 9'h011);
        step();
        in_tag = 9'h012;
        step();
        in_valid = 1'b0;
        check_eq("rmid_full", 32'(in_ready), 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rmid_valid", 32'(out_valid), 32'd0);
        check_eq("rmid_ready", 32'(in_ready),  32'd1);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check_eq("rmid_gone1", 32'(out_valid), 32'd0);
        step();
        check_eq("rmid_gone2", 32'(out_valid), 32'd0);

        // Write to r5 followed by a read of r5
        offer(3'd1, 3'd1, 3'd5, 1'b1, 9'h050);
        step();
        offer(3'd5, 3'd0, 3'd0, 1'b0, 9'h055);
`ifdef OPFETCH_SCOREBOARD_EN
        #1;
        check_eq("sb_stall_ready", 32'(in_ready), 32'd0);
        step();
        check_eq("sb_stall_valid", 32'(out_valid), 32'd0);
        wb_en = 1'b1; wb_addr = 3'd5; wb_dat = 8'h33;
        #1;
        check_eq("sb_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0; wb_en = 1'b0;
        check_eq("sb_valid", 32'(out_valid), 32'd1);
        check_eq("sb_a",     32'(out_a),     32'h33);
        check_eq("sb_tag",   32'(out_tag),   32'h055);
`else
        #1;
        check_eq("nosb_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_eq("nosb_valid", 32'(out_valid), 32'd1);
        check_eq("nosb_a",     32'(out_a),     32'h44);
        check_eq("nosb_tag",   32'(out_tag),   32'h055);
`endif
        step();
        check_eq("end_drain", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
